arbiter_4req: RTL and testbench

//  Shares one downstream resource between 4 requesters with a registered, held grant.

---
 rtl/arb_pkg.sv | 29 ++
 rtl/prio_enc_4.sv | 25 ++
 rtl/arbiter_4req.sv | 152 +++++++++++++++
 tb/tb_arbiter_4req.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
//  Shared definitions for the 4-requester arbiter.
//  Contents:
//   N_REQ        number of requesters (4)
//   arb_state_t  arbiter FSM state encoding {IDLE, BUSY}
//   rotate4()    rotate-right of a 4-bit request vector. It is used to present
//                the round-robin search order to a fixed-priority encoder.
// -----------------------------------------------------------------------------
package arb_pkg;

   localparam int N_REQ = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   // Rotate right by sh: result[k] = req[(k + sh) mod 4].
   // With sh = last_idx, bit 3 of the result is req[last_idx-1]. The priority
   // encoder therefore searches last_idx-1, last_idx-2, ... with wrap.
   function automatic logic [N_REQ-1:0] rotate4(input logic [N_REQ-1:0] req,
                                                 input logic [1:0]       sh);
      logic [2*N_REQ-1:0] dbl;
      dbl = {req, req} >> sh;
      return dbl[N_REQ-1:0];
   endfunction

endpackage

// File: rtl/prio_enc_4.sv
// -----------------------------------------------------------------------------
// prio_enc_4
//  Combinational 4-input priority encoder. Bit 3 has the highest priority.
//  Ports:
//   req_i   [3:0] in   request vector
//   valid_o       out  high when any request bit is set
//   idx_o   [1:0] out  index of the highest set bit; 0 when none is set
// -----------------------------------------------------------------------------
module prio_enc_4
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] req_i,
   output logic             valid_o,
   output logic [1:0]       idx_o
);

   always_comb begin
      valid_o = |req_i;
      idx_o   = 2'd0;
      if (req_i[3])      idx_o = 2'd3;
      else if (req_i[2]) idx_o = 2'd2;
      else if (req_i[1]) idx_o = 2'd1;
   end

endmodule

// File: rtl/arbiter_4req.sv
// -----------------------------------------------------------------------------
// arbiter_4req
//  Shares one downstream resource between 4 requesters. The grant is
//  registered and held. A grant ends when its requester drops its request or
//  when the grant reaches MAX_HOLD BUSY cycles. After every release the
//  arbiter spends one idle cycle with gnt = 0.
//  Configuration macro:
//   ARB_RR_EN  undefined: fixed priority 3>2>1>0
//              defined:   round-robin. The search starts below the last
//                         granted index.
//  Parameters:
//   MAX_HOLD  max consecutive BUSY cycles per grant (>= 2)
//   CNT_W     hold counter width, 2**CNT_W > MAX_HOLD
//  Ports:
//   clk           in   clock, rising edge
//   rst           in   asynchronous active-high reset
//   req     [3:0] in   request per requester
//   gnt     [3:0] out  one-hot grant, 0 when idle
//   gnt_idx [1:0] out  binary index of the granted requester, 0 when idle
//   busy          out  a grant is held
//   timeout       out  one-cycle pulse after a grant is force-released
// -----------------------------------------------------------------------------
module arbiter_4req
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [1:0]       gnt_idx,
   output logic             busy,
   output logic             timeout
);

   arb_state_t       state_q, state_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [1:0]       gnt_idx_q, gnt_idx_d;
   logic             timeout_q, timeout_d;

   logic [N_REQ-1:0] enc_req;
   logic             enc_valid;
   logic [1:0]       enc_idx;
   logic [1:0]       rot_sh;
   logic [1:0]       win_idx;
   logic             owner_req;
   logic             hold_at_max;

`ifdef ARB_RR_EN
   logic [1:0] last_idx_q, last_idx_d;

   assign rot_sh = last_idx_q;

   // The last winner updates only when a new grant is issued.
   always_comb begin
      last_idx_d = last_idx_q;
      if (state_q == IDLE && enc_valid) last_idx_d = win_idx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_idx_q <= 2'd0;
      else     last_idx_q <= last_idx_d;
   end
`else
   assign rot_sh = 2'd0;
`endif

   assign enc_req = rotate4(req, rot_sh);

   prio_enc_4 u_prio_enc (
      .req_i   (enc_req),
      .valid_o (enc_valid),
      .idx_o   (enc_idx)
   );

   // Un-rotate the index. The 2-bit add wraps mod 4.
   assign win_idx     = enc_idx + rot_sh;
   assign owner_req   = req[gnt_idx_q];
   assign hold_at_max = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         hold_cnt_q <= '0;
         gnt_q      <= '0;
         gnt_idx_q  <= 2'd0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         gnt_q      <= gnt_d;
         gnt_idx_q  <= gnt_idx_d;
         timeout_q  <= timeout_d;
      end
   end

   // Next-state logic. Every release goes back to IDLE. IDLE cannot grant in
   // the same cycle it is entered, so each release is followed by a dead cycle.
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         IDLE: begin
            if (enc_valid) begin
               state_d    = BUSY;
               hold_cnt_d = '0;
            end
         end
         BUSY: begin
            if (!owner_req || hold_at_max) state_d    = IDLE;
            else                           hold_cnt_d = hold_cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs
   always_comb begin
      gnt_d     = '0;
      gnt_idx_d = 2'd0;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (enc_valid) begin
               gnt_d     = 4'b0001 << win_idx;
               gnt_idx_d = win_idx;
            end
         end
         BUSY: begin
            if (owner_req && !hold_at_max) begin
               gnt_d     = gnt_q;
               gnt_idx_d = gnt_idx_q;
            end else if (owner_req) begin
               // A voluntary release at the limit takes the branch above
               // being false via !owner_req, so it never flags a timeout.
               timeout_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign gnt     = gnt_q;
   assign gnt_idx = gnt_idx_q;
   assign busy    = (state_q == BUSY);
   assign timeout = timeout_q;

endmodule

// File: tb/tb_arbiter_4req.sv
module tb_arbiter_4req;

   localparam int MAX_HOLD = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       busy;
   logic       timeout;

   typedef struct {
      logic [3:0] gnt;
      logic [1:0] idx;
      logic       busy;
      logic       timeout;
      string      tag;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

`ifdef ARB_RR_EN
   int order[5] = '{3, 2, 1, 0, 3};
`else
   int order[5] = '{3, 3, 3, 3, 3};
`endif

   arbiter_4req #(.MAX_HOLD(MAX_HOLD), .CNT_W(5)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .busy    (busy),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   // Per-cycle structural checks
   always @(negedge clk) begin
      logic [3:0] shaped;
      shaped = 4'(busy) << gnt_idx;
      n_tests++;
      assert ($onehot0(gnt) && (gnt === shaped) && !(timeout && busy)) else begin
         n_fail++;
         $error("FAIL invariant gnt=%b gnt_idx=%0d busy=%b timeout=%b", gnt, gnt_idx, busy, timeout);
      end
   end

   task automatic push_exp(input logic [3:0] g, input logic [1:0] i, input logic b,
                           input logic t, input string tag);
      exp_t e;
      e.gnt = g; e.idx = i; e.busy = b; e.timeout = t; e.tag = tag;
      sb_q.push_back(e);
   endtask

   task automatic check_out();
      exp_t       e;
      logic [7:0] obs, want;
      n_tests++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty got gnt=%b want an entry", gnt);
      end else begin
         e    = sb_q.pop_front();
         obs  = {gnt, gnt_idx, busy, timeout};
         want = {e.gnt, e.idx, e.busy, e.timeout};
         $display("[TB] %-16s req=%b gnt=%b idx=%0d busy=%b timeout=%b", e.tag, req, gnt, gnt_idx, busy, timeout);
         assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s got {gnt,idx,busy,to}=%b_%b_%b_%b want %b_%b_%b_%b", e.tag,
                   gnt, gnt_idx, busy, timeout, e.gnt, e.idx, e.busy, e.timeout);
         end
      end
   endtask

   // Drive req, expect the given outputs after the next rising edge.
   task automatic cycle(input logic [3:0] r, input logic [3:0] g, input logic [1:0] i,
                        input logic b, input logic t, input string tag);
      req = r;
      push_exp(g, i, b, t, tag);
      @(posedge clk);
      #1;
      check_out();
   endtask

   task automatic grant(input logic [3:0] r, input logic [1:0] w, input string tag);
      cycle(r, 4'b0001 << w, w, 1'b1, 1'b0, tag);
   endtask

   initial begin
      logic [1:0] w;
      rst = 1'b1;
      req = 4'b0000;
      #1;
      push_exp(4'b0, 2'd0, 1'b0, 1'b0, "reset_async");
      check_out();
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Idle with no requests
      cycle(4'b0000, 4'b0, 2'd0, 1'b0, 1'b0, "idle_noreq");

      // Test 1: highest of 1010 wins
      grant(4'b1010, 2'd3, "t1_grant3");
      grant(4'b1010, 2'd3, "t1_hold3");

      // Test 2: owner drops -> one dead cycle, then requester 1
      cycle(4'b0010, 4'b0, 2'd0, 1'b0, 1'b0, "t2_dead");
      grant(4'b0010, 2'd1, "t2_grant1");
      cycle(4'b0000, 4'b0, 2'd0, 1'b0, 1'b0, "t2_release");

      // Test 3: 20 cycles of req0 -> 16 held, timeout, dead, re-grant
      grant(4'b0001, 2'd0, "t3_grant0");
      for (int k = 0; k < MAX_HOLD - 1; k++) grant(4'b0001, 2'd0, "t3_hold");
      cycle(4'b0001, 4'b0, 2'd0, 1'b0, 1'b1, "t3_timeout");
      grant(4'b0001, 2'd0, "t3_regrant");
      grant(4'b0001, 2'd0, "t3_hold2");
      grant(4'b0001, 2'd0, "t3_hold3");
      cycle(4'b0000, 4'b0, 2'd0, 1'b0, 1'b0, "t3_release");

      // Test 4: all request; owner briefly drops to release
      for (int k = 0; k < 5; k++) begin
         w = order[k][1:0];
         grant(4'b1111, w, "t4_grant");
         cycle(4'b1111 & ~(4'b0001 << w), 4'b0, 2'd0, 1'b0, 1'b0, "t4_release");
      end
      cycle(4'b0000, 4'b0, 2'd0, 1'b0, 1'b0, "t4_idle");

      // Test 5: async reset mid-grant clears outputs before the next edge
      grant(4'b0100, 2'd2, "t5_grant2");
      grant(4'b0100, 2'd2, "t5_hold2");
      #2;
      rst = 1'b1;
      #1;
      push_exp(4'b0, 2'd0, 1'b0, 1'b0, "t5_rst_midbusy");
      check_out();
      @(posedge clk);
      #1;
      rst = 1'b0;
      cycle(4'b0000, 4'b0, 2'd0, 1'b0, 1'b0, "t5_after_rst");

      // Test 6: release in the same cycle as the hold limit -> no timeout
      grant(4'b0100, 2'd2, "t6_grant2");
      for (int k = 0; k < MAX_HOLD - 1; k++) grant(4'b0100, 2'd2, "t6_hold");
      cycle(4'b0000, 4'b0, 2'd0, 1'b0, 1'b0, "t6_rel_at_limit");
      cycle(4'b0000, 4'b0, 2'd0, 1'b0, 1'b0, "t6_idle");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
